// File: rtl/stage_to_out.sv
// stage_to_out: drains a completed FFT stage memory one sample per clock, pairing each with its mstore metadata.
// Define STAGE_TO_OUT_BITREV_EN to read the stage memory in bit-reversed address order.
module stage_to_out #(
    parameter int N      = 8,
    parameter int LOG_N  = 3,
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [LOG_N-1:0]  out_addr,
    output logic              out_rd,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_mfull,
    input  logic [MWIDTH-1:0] in_m,
    output logic              m_delete,
    output logic              out_nd,
    output logic [WIDTH-1:0]  out_data,
    output logic [MWIDTH-1:0] out_m,
    output logic              finished,
    output logic              error
);
    typedef enum logic {IDLE, DRAIN} state_t;
    localparam logic [LOG_N-1:0] LAST_ADDR = LOG_N'(N - 1);
    state_t              state_q;
    logic [LOG_N-1:0]    addr_q;
    logic                rd_q;
    logic                last_q;
    logic                error_q;
    logic [MWIDTH-1:0]   m_q;
    logic                issue;
    // A start seen while draining steals the cycle, so no read is issued then.
    assign issue = (state_q == DRAIN) && in_mfull && !start;
`ifdef STAGE_TO_OUT_BITREV_EN
    for (genvar i = 0; i < LOG_N; i++) begin : g_rev
        assign out_addr[i] = addr_q[LOG_N-1-i];
    end
`else
    assign out_addr = addr_q;
`endif
    assign out_rd   = issue;
    assign m_delete = issue;
    assign out_nd   = rd_q;
    assign out_data = in_data;
    assign out_m    = m_q;
    assign finished = last_q;
    assign error    = error_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            rd_q   <= issue;
            last_q <= issue && (addr_q == LAST_ADDR);
            if (start && state_q == DRAIN)
                error_q <= 1'b1;
            if (state_q == IDLE && start) begin
                state_q <= DRAIN;
                addr_q  <= '0;
            end else if (issue) begin
                if (addr_q == LAST_ADDR)
                    state_q <= IDLE;
                else
                    addr_q <= addr_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (issue)
            m_q <= in_m;
    end
endmodule

// File: tb/tb_stage_to_out.sv
// tb_stage_to_out: scoreboard bench for stage_to_out with a stage memory and mstore model.
module tb_stage_to_out;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  out_addr;
    logic        out_rd;
    logic [31:0] in_data;
    logic        in_mfull;
    logic [0:0]  in_m;
    logic        m_delete;
    logic        out_nd;
    logic [31:0] out_data;
    logic [0:0]  out_m;
    logic        finished;
    logic        error;

    typedef struct packed {
        logic [31:0] data;
        logic        m;
        logic        fin;
    } exp_t;

    exp_t sb[$];
    int   nd_cyc[$];
    int   cyc = 0;
    int   pop_cnt = 0;
    int   n_out = 0, n_pop = 0, n_fin = 0;
    int   vecs = 0, errs = 0;
    int   s_out, s_pop, s_fin, e;
`ifdef STAGE_TO_OUT_BITREV_EN
    int   order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int   order[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    stage_to_out dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_addr(out_addr), .out_rd(out_rd),
        .in_data(in_data), .in_mfull(in_mfull), .in_m(in_m), .m_delete(m_delete),
        .out_nd(out_nd), .out_data(out_data), .out_m(out_m), .finished(finished), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (out_rd) in_data <= 32'(100 + int'(out_addr));
    always @(posedge clk) if (m_delete) pop_cnt <= pop_cnt + 1;
    assign in_m = 1'(pop_cnt & 1);

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m_delete) n_pop++;
        if (finished) n_fin++;
        if (finished && !out_nd) chk("finished_without_nd", 1, 0);
        if (out_nd) begin
            exp_t x;
            nd_cyc.push_back(cyc);
            n_out++;
            if (sb.size() == 0) chk("unexpected_out_nd", 1, 0);
            else begin
                x = sb.pop_front();
                chk("out_data", out_data, x.data);
                chk("out_m", out_m, x.m);
                chk("finished", finished, x.fin);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_drain();
        for (int i = 0; i < 8; i++)
            sb.push_back('{data: 32'(100 + order[i]), m: 1'(i & 1), fin: (i == 7)});
    endtask

    task automatic snap();
        s_out = n_out; s_pop = n_pop; s_fin = n_fin;
        nd_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        e = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
        chk("drain_timeout_left", sb.size(), 0);
        tick(3);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_mfull = 1'b1;
        tick(2);
        chk("rst_out_nd", out_nd, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_m_delete", m_delete, 0);
        chk("rst_finished", finished, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_no_rd", out_rd, 0);

        snap(); push_drain(); pulse_start(); wait_done();
        chk("t1_outputs", n_out - s_out, 8);
        chk("t1_pops", n_pop - s_pop, 8);
        chk("t1_finished", n_fin - s_fin, 1);
        chk("t1_first_nd", nd_cyc[0], e + 2);
        chk("t1_last_nd", nd_cyc[7], e + 9);
        chk("t1_error", error, 0);

        snap(); push_drain(); pulse_start();
        tick(4); in_mfull = 1'b0;
        tick(3); in_mfull = 1'b1;
        wait_done();
        chk("t2_outputs", n_out - s_out, 8);
        chk("t2_gap", nd_cyc[4] - nd_cyc[3], 4);
        chk("t2_pops", n_pop - s_pop, 8);
        chk("t2_finished", n_fin - s_fin, 1);

        snap(); push_drain(); pulse_start();
        tick(); start = 1'b1; tick(); start = 1'b0;
        wait_done();
        chk("t3_error", error, 1);
        chk("t3_outputs", n_out - s_out, 8);
        chk("t3_finished", n_fin - s_fin, 1);
        tick(5);
        chk("t3_error_sticky", error, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        chk("t3_error_cleared", error, 0);

        snap(); push_drain(); pulse_start();
        tick(3); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        chk("t4_outputs_before_rst", n_out - s_out, 3);
        sb.delete();
        snap(); tick(10);
        chk("t4_no_nd", n_out - s_out, 0);
        chk("t4_no_pop", n_pop - s_pop, 0);
        chk("t4_no_fin", n_fin - s_fin, 0);
        chk("t4_error", error, 0);
        snap(); push_drain(); pulse_start(); wait_done();
        chk("t4_redrain_outputs", n_out - s_out, 8);
        chk("t4_redrain_finished", n_fin - s_fin, 1);

        snap(); push_drain(); push_drain(); pulse_start();
        tick(8); pulse_start(); wait_done();
        chk("t5_outputs", n_out - s_out, 16);
        chk("t5_finished", n_fin - s_fin, 2);
        chk("t5_pops", n_pop - s_pop, 16);
        chk("t5_error", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
